// File: rtl/fibo_pkg.sv
// Shared definitions for the Fibonacci sequencer slice.
// Contents:
//   ST_IDLE/ST_EMIT/ST_DONE : FSM state encodings
//   FIBO_SEED0/FIBO_SEED1   : default seed pair (0, 1)
package fibo_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EMIT = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int FIBO_SEED0 = 0;
  localparam int FIBO_SEED1 = 1;

endpackage

// File: rtl/fibo_core.sv
// Fibonacci datapath: two term registers and the adder between them.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   load            : capture seed0/seed1 into cur/nxt
//   step            : advance cur<=nxt, nxt<=cur+nxt (low WIDTH bits)
//   seed0, seed1    : seed pair used on load
//   cur, nxt        : current and next term
//   carry           : carry-out of cur+nxt (the value step would write)
module fibo_core #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] seed0,
  input  logic [WIDTH-1:0] seed1,
  output logic [WIDTH-1:0] cur,
  output logic [WIDTH-1:0] nxt,
  output logic             carry
);

  logic [WIDTH-1:0] cur_q, cur_d;
  logic [WIDTH-1:0] nxt_q, nxt_d;
  logic [WIDTH:0]   sum;

  assign sum   = {1'b0, cur_q} + {1'b0, nxt_q};
  assign carry = sum[WIDTH];

  always_comb begin
    cur_d = cur_q;
    nxt_d = nxt_q;
    if (load) begin
      cur_d = seed0;
      nxt_d = seed1;
    end else if (step) begin
      cur_d = nxt_q;
      nxt_d = sum[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_q <= '0;
      nxt_q <= '0;
    end else begin
      cur_q <= cur_d;
      nxt_q <= nxt_d;
    end
  end

  assign cur = cur_q;
  assign nxt = nxt_q;

endmodule

// File: rtl/fibo_seq_ctrl.sv
// Sequencer for the Fibonacci datapath: accepts a start with a term count,
// seeds the datapath, emits one term per accepted beat on a valid/ready
// stream and stops early if the next term would overflow WIDTH bits.
// Ports:
//   clk, reset      : clock, asynchronous active-low reset
//   seed0, seed1    : seed pair (only when FIBO_SEED_EN is defined)
//   start,num_terms : run request, sampled in IDLE only
//   busy            : run in progress (EMIT or DONE)
//   term_out/term_valid/term_ready/term_last : output term stream
//   ovf             : sticky, run ended by overflow
//   done            : one-cycle end-of-run pulse
// Build option: FIBO_SEED_EN adds the seed0/seed1 inputs; otherwise the
// seeds are fixed at 0 and 1.
module fibo_seq_ctrl
  import fibo_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
`ifdef FIBO_SEED_EN
  input  logic [WIDTH-1:0] seed0,
  input  logic [WIDTH-1:0] seed1,
`endif
  input  logic             start,
  input  logic [CNT_W-1:0] num_terms,
  output logic             busy,
  output logic [WIDTH-1:0] term_out,
  output logic             term_valid,
  input  logic             term_ready,
  output logic             term_last,
  output logic             ovf,
  output logic             done
);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             nxt_ovf_q, nxt_ovf_d;
  logic             ovf_q, ovf_d;
  logic             load, step;
  logic [WIDTH-1:0] seed0_w, seed1_w;
  logic [WIDTH-1:0] cur, nxt;
  logic             carry;
  logic             last_beat;

`ifdef FIBO_SEED_EN
  assign seed0_w = seed0;
  assign seed1_w = seed1;
`else
  assign seed0_w = WIDTH'(FIBO_SEED0);
  assign seed1_w = WIDTH'(FIBO_SEED1);
`endif

  fibo_core #(.WIDTH(WIDTH)) u_core (
    .clk   (clk),
    .rst_n (reset),
    .load  (load),
    .step  (step),
    .seed0 (seed0_w),
    .seed1 (seed1_w),
    .cur   (cur),
    .nxt   (nxt),
    .carry (carry)
  );

  assign last_beat = (rem_q == CNT_W'(1));

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    nxt_ovf_d = nxt_ovf_q;
    ovf_d     = ovf_q;
    load      = 1'b0;
    step      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          ovf_d = 1'b0;
          if (num_terms != '0) begin
            load      = 1'b1;
            rem_d     = num_terms;
            nxt_ovf_d = 1'b0;
            state_d   = ST_EMIT;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_EMIT: begin
        if (term_ready) begin
          if (last_beat) begin
            state_d = ST_DONE;
          end else if (nxt_ovf_q) begin
            // nxt already wrapped: the term it holds cannot be emitted.
            ovf_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            step      = 1'b1;
            nxt_ovf_d = carry;
            rem_d     = rem_q - CNT_W'(1);
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      rem_q     <= '0;
      nxt_ovf_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      nxt_ovf_q <= nxt_ovf_d;
      ovf_q     <= ovf_d;
    end
  end

  assign busy       = (state_q != ST_IDLE);
  assign term_valid = (state_q == ST_EMIT);
  assign term_last  = (state_q == ST_EMIT) && last_beat;
  assign term_out   = cur;
  assign ovf        = ovf_q;
  assign done       = (state_q == ST_DONE);

endmodule
